// File: rtl/cyclic_mul_ctrl_pkg.sv
// cyclic_mul_ctrl_pkg: shared states, operand geometry and top-word mask helper
package cyclic_mul_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, MAC, FOLD, FIN} state_t;
  localparam int MAX_W = 1024;
  function automatic int words(input int r, input int w);
    return (r + w - 1) / w;
  endfunction
  function automatic int top_bits(input int r, input int w);
    return r - (words(r, w) - 1) * w;
  endfunction
  function automatic logic [MAX_W-1:0] low_mask(input int s);
    return (MAX_W'(1) << s) - MAX_W'(1);
  endfunction
endpackage

// File: rtl/cyclic_mul_ctrl_gf2_clmul.sv
// gf2_clmul: combinational W x W carry-less multiplier
module gf2_clmul #(
  parameter int W = 64
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-2:0] p
);
  always_comb begin
    p = '0;
    for (int n = 0; n < W; n++) p = b[n] ? p ^ ((2*W-1)'(a) << n) : p;
  end
endmodule

// File: rtl/cyclic_mul_ctrl.sv
// cyclic_mul_ctrl: word-serial c = a*b (or c ^= a*b) mod x^R-1 over GF(2) on external BRAMs
module cyclic_mul_ctrl #(
  parameter int R      = 10163,
  parameter int W      = 64,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] op0_addra,
  input  logic [W-1:0]      op0_dina,
  output logic [ADDR_W-1:0] op1_addra,
  input  logic [W-1:0]      op1_dina,
  output logic [ADDR_W-1:0] re_addra,
  input  logic [W-1:0]      re_dina,
  output logic [ADDR_W-1:0] re_addrb,
  output logic              re_web,
  output logic [W-1:0]      re_doutb,
  input  logic [W-1:0]      re_dinb
);
  import cyclic_mul_ctrl_pkg::*;
  localparam int D  = words(R, W);
  localparam int S  = top_bits(R, W);
  localparam int CW = ADDR_W + 1;
  localparam logic [W-1:0]      TMASK = W'(low_mask(S));
  localparam logic [ADDR_W-1:0] DA    = ADDR_W'(D);
  localparam logic [ADDR_W-1:0] DL    = ADDR_W'(D - 1);
  localparam logic [ADDR_W-1:0] ML    = ADDR_W'(D + 2);
  localparam logic [CW-1:0]     CLR0  = CW'(2 * D - 1);
  localparam logic [CW-1:0]     CLR1  = CW'(D - 1);
  localparam logic [CW-1:0]     FLAST = CW'(2 * D + 1);

  state_t state, state_d;
  logic mode_q, s1_v, s2_v, mac_last, clr_last;
  logic [CW-1:0] cnt, fk;
  logic [ADDR_W-1:0] i, m, k, s1_j, s1_addr, s2_j, s2_addr;
  logic [2*W-2:0] prod, prod_q;
  logic [W-1:0] a_m, b_m, pd_q, carry, slide, hk, mac_word, fold_word;

  assign a_m = op0_dina & (i == DL ? TMASK : '1);
  assign b_m = op1_dina & (s1_j == DL ? TMASK : '1);

  gf2_clmul #(.W(W)) u_clmul (.a(a_m), .b(b_m), .p(prod));

  // fold word index: FOLD spends two prefetch cycles on P[D-1], then two cycles per word
  assign fk        = cnt - CW'(2);
  assign k         = fk[ADDR_W:1];
  assign hk        = W'({re_dina, slide} >> S);
  assign fold_word = (re_dinb ^ hk) & (k == DL ? TMASK : '1);
  assign mac_word  = pd_q ^ prod_q[W-1:0] ^ (s2_j == '0 ? '0 : carry);
  assign mac_last  = i == DL && m == ML;
  assign clr_last  = cnt == (mode_q ? CLR1 : CLR0);

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mode_q  <= 1'b0;
      cnt     <= '0;
      i       <= '0;
      m       <= '0;
      s1_v    <= 1'b0;
      s1_j    <= '0;
      s1_addr <= '0;
      s2_v    <= 1'b0;
      s2_j    <= '0;
      s2_addr <= '0;
      pd_q    <= '0;
      prod_q  <= '0;
      carry   <= '0;
      slide   <= '0;
    end else begin
      state   <= state_d;
      busy    <= state != IDLE && state != FIN;
      done    <= state == FIN;
      mode_q  <= state == IDLE && start ? mode : mode_q;
      cnt     <= state_d != state ? '0 : cnt + 1'b1;
      m       <= state == MAC && m != ML ? m + 1'b1 : '0;
      i       <= state != MAC ? '0 : m == ML ? i + 1'b1 : i;
      s1_v    <= state == MAC && m <= DA;
      s1_j    <= m;
      s1_addr <= i + m;
      s2_v    <= s1_v;
      s2_j    <= s1_j;
      s2_addr <= s1_addr;
      pd_q    <= re_dina;
      prod_q  <= s1_j == DA ? '0 : prod;
      carry   <= s2_v ? W'(prod_q[2*W-2:W]) : carry;
      slide   <= state == FOLD && cnt[0] ? re_dina : slide;
    end

  always_comb begin
    state_d   = state;
    op0_addra = '0;
    op1_addra = '0;
    re_addra  = '0;
    re_addrb  = '0;
    re_web    = 1'b0;
    re_doutb  = '0;
    case (state)
      IDLE:  state_d = start ? CLEAR : IDLE;
      CLEAR: begin
        state_d  = clr_last ? MAC : CLEAR;
        re_web   = 1'b1;
        re_addrb = (mode_q ? DA : '0) + cnt[ADDR_W-1:0];
      end
      MAC: begin
        state_d   = mac_last ? FOLD : MAC;
        op0_addra = i;
        op1_addra = m;
        re_addra  = i + m;
        re_web    = s2_v;
        re_addrb  = s2_addr;
        re_doutb  = s2_v ? mac_word : '0;
      end
      FOLD: begin
        state_d  = cnt == FLAST ? FIN : FOLD;
        re_addra = cnt == '0 ? DL : DA + k;
        re_addrb = k;
        re_web   = cnt[0] && cnt != CW'(1);
        re_doutb = cnt[0] && cnt != CW'(1) ? fold_word : '0;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cyclic_mul_ctrl.sv
// tb_cyclic_mul_ctrl: randomized bench against a polynomial-ring reference model
module tb_cyclic_mul_ctrl;
  localparam int R1 = 131, W1 = 16, AW = 9;
  localparam int D1 = (R1 + W1 - 1) / W1, S1 = R1 - (D1 - 1) * W1;
  localparam int L0 = 2 * D1 + D1 * (D1 + 3) + 2 * D1 + 3, L1 = L0 - D1;
  localparam int R2 = 10163, W2 = 64, D2 = (R2 + W2 - 1) / W2;
  localparam int L2 = 2 * D2 + D2 * (D2 + 3) + 2 * D2 + 3;

  logic clk = 1'b0, rst_b = 1'b0, start = 1'b0, mode = 1'b0;
  logic busy, done, re_web;
  logic [AW-1:0] op0_addra, op1_addra, re_addra, re_addrb;
  logic [W1-1:0] op0_dina, op1_dina, re_dina, re_dinb, re_doutb;
  logic [W1-1:0] op0_mem [512], op1_mem [512], re_mem [512];

  logic b_start = 1'b0, b_busy, b_done, b_web;
  logic [AW-1:0] b_op0_addra, b_op1_addra, b_re_addra, b_re_addrb;
  logic [W2-1:0] b_op0_dina, b_op1_dina, b_re_dina, b_re_dinb, b_re_doutb;
  logic [W2-1:0] b_op0_mem [512], b_op1_mem [512], b_re_mem [512];

  int n_chk = 0, n_pass = 0;
  logic [R1-1:0] cur_c, ta, tb_b;
  logic [R2-1:0] exp_big;
  logic [W2-1:0] e_word;

  always #5 clk = ~clk;

  cyclic_mul_ctrl #(.R(R1), .W(W1), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_b(rst_b), .start(start), .mode(mode), .busy(busy), .done(done),
    .op0_addra(op0_addra), .op0_dina(op0_dina), .op1_addra(op1_addra), .op1_dina(op1_dina),
    .re_addra(re_addra), .re_dina(re_dina), .re_addrb(re_addrb), .re_web(re_web),
    .re_doutb(re_doutb), .re_dinb(re_dinb)
  );

  cyclic_mul_ctrl u_big (
    .clk(clk), .rst_b(rst_b), .start(b_start), .mode(1'b0), .busy(b_busy), .done(b_done),
    .op0_addra(b_op0_addra), .op0_dina(b_op0_dina), .op1_addra(b_op1_addra), .op1_dina(b_op1_dina),
    .re_addra(b_re_addra), .re_dina(b_re_dina), .re_addrb(b_re_addrb), .re_web(b_web),
    .re_doutb(b_re_doutb), .re_dinb(b_re_dinb)
  );

  // single-cycle-latency BRAMs, port B read-first
  always @(posedge clk) begin
    op0_dina <= op0_mem[op0_addra];
    op1_dina <= op1_mem[op1_addra];
    re_dina  <= re_mem[re_addra];
    re_dinb  <= re_mem[re_addrb];
    if (re_web) re_mem[re_addrb] <= re_doutb;
    b_op0_dina <= b_op0_mem[b_op0_addra];
    b_op1_dina <= b_op1_mem[b_op1_addra];
    b_re_dina  <= b_re_mem[b_re_addra];
    b_re_dinb  <= b_re_mem[b_re_addrb];
    if (b_web) b_re_mem[b_re_addrb] <= b_re_doutb;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [R1-1:0] mulmod(input logic [R1-1:0] a, input logic [R1-1:0] b);
    logic [R1-1:0] c = '0;
    for (int v = 0; v < R1; v++)
      if (b[v]) for (int u = 0; u < R1; u++) if (a[u]) c[(u + v) % R1] ^= 1'b1;
    return c;
  endfunction

  function automatic logic [R1-1:0] rnd_poly();
    logic [R1-1:0] p;
    for (int n = 0; n < R1; n++) p[n] = 1'($urandom % 2);
    return p;
  endfunction

  function automatic logic [R1-1:0] collect();
    logic [R1-1:0] c = '0;
    for (int k = 0; k < D1; k++)
      for (int n = 0; n < W1; n++) if (k * W1 + n < R1) c[k * W1 + n] = re_mem[k][n];
    return c;
  endfunction

  task automatic load(input logic [R1-1:0] a, input logic [R1-1:0] b, input logic garb);
    for (int k = 0; k < D1; k++)
      for (int n = 0; n < W1; n++) begin
        op0_mem[k][n] = k * W1 + n < R1 ? a[k * W1 + n] : garb & 1'($urandom % 2);
        op1_mem[k][n] = k * W1 + n < R1 ? b[k * W1 + n] : garb & 1'($urandom % 2);
      end
  endtask

  task automatic run(input logic [R1-1:0] a, input logic [R1-1:0] b, input logic md,
                     input logic garb, input logic extra, input string tag);
    int lat = 0, ndone = 0;
    logic [R1-1:0] exp;
    load(a, b, garb);
    exp = md ? cur_c ^ mulmod(a, b) : mulmod(a, b);
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= L0 + 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) check({tag, " busy"}, 256'(busy), 256'(1));
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = n;
          check({tag, " busy@done"}, 256'(busy), 256'(0));
        end
      end
      start = extra && n == 30;
      mode  = start ? ~md : md;
    end
    check({tag, " latency"}, 256'(lat), 256'(md ? L1 : L0));
    check({tag, " done count"}, 256'(ndone), 256'(1));
    check({tag, " result"}, 256'(collect()), 256'(exp));
    check({tag, " pad"}, 256'(re_mem[D1-1] >> S1), 256'(0));
    cur_c = exp;
  endtask

  initial begin
    cur_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 256'(busy), 256'(0));
    check("rst done", 256'(done), 256'(0));
    check("rst web", 256'(re_web), 256'(0));
    check("rst addr", 256'({op0_addra, op1_addra, re_addra, re_addrb}), 256'(0));
    check("rst dout", 256'(re_doutb), 256'(0));
    check("rst big busy", 256'(b_busy), 256'(0));
    @(negedge clk);
    rst_b = 1'b1;

    run(R1'(1), R1'(1) << 5, 1'b0, 1'b0, 1'b0, "x5");
    check("x5 P0", 256'(re_mem[0]), 256'(16'h0020));
    run(R1'(1) << 130, R1'(1) << 1, 1'b0, 1'b0, 1'b0, "wrap");
    check("wrap c", 256'(collect()), 256'(1));
    run({R1{1'b1}}, {R1{1'b1}}, 1'b0, 1'b0, 1'b0, "ones");
    check("ones c", 256'(collect()), 256'({R1{1'b1}}));
    run({R1{1'b1}}, {R1{1'b1}}, 1'b1, 1'b0, 1'b0, "acc");
    check("acc c", 256'(collect()), 256'(0));
    run(rnd_poly(), rnd_poly(), 1'b0, 1'b1, 1'b1, "busy start");
    for (int t = 0; t < 6; t++)
      run(rnd_poly(), rnd_poly(), 1'($urandom % 2), 1'($urandom % 2), t == 3, "rand");

    ta   = rnd_poly();
    tb_b = rnd_poly();
    load(ta, tb_b, 1'b0);
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * D1 + 40) @(posedge clk);
    #1;
    check("pre-rst busy", 256'(busy), 256'(1));
    rst_b = 1'b0;
    #1;
    check("mid-rst busy", 256'(busy), 256'(0));
    check("mid-rst done", 256'(done), 256'(0));
    check("mid-rst web", 256'(re_web), 256'(0));
    @(negedge clk);
    rst_b = 1'b1;
    run(ta, tb_b, 1'b0, 1'b0, 1'b0, "after rst");

    for (int k = 0; k < 512; k++) begin
      b_op0_mem[k] = '0;
      b_op1_mem[k] = '0;
    end
    b_op0_mem[0] = W2'(1);
    b_op1_mem[0] = W2'(1) << 5;
    exp_big = '0;
    exp_big[5 % R2] = 1'b1;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    begin
      int lat = 0, bad = 0;
      for (int n = 1; n <= L2 + 10 && lat == 0; n++) begin
        @(posedge clk);
        #1;
        if (b_done) lat = n;
      end
      check("big latency", 256'(lat), 256'(L2));
      for (int k = 0; k < D2; k++) begin
        e_word = '0;
        for (int n = 0; n < W2; n++) if (k * W2 + n < R2) e_word[n] = exp_big[k * W2 + n];
        if (b_re_mem[k] !== e_word) bad++;
      end
      check("big bad words", 256'(bad), 256'(0));
      check("big P0", 256'(b_re_mem[0]), 256'(64'h20));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
